uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 104, clk cycles per serial bit (legal range 2..65535).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, byte entries buffered ahead of the shifter (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port wr_valid  input  1  CPU store strobe offering wr_data.
REQ-006 SHALL have port wr_data  input  8  byte to transmit, sampled only on accept.
REQ-007 SHALL have port wr_ready  output  1  high when FIFO count < FIFO_DEPTH.
REQ-008 SHALL have port tx  output  1  serial line, registered, idle high; drives the CPU's uart_tx_wire.
REQ-009 SHALL have port busy  output  1  high when shifter not IDLE or FIFO non-empty.
REQ-010 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-011 SHALL accept a byte on a rising edge where wr_valid and wr_ready are both high; wr_valid while wr_ready is low SHALL be ignored without side effects.
REQ-012 SHALL compute wr_ready from registered count only; no bypass: a full FIFO SHALL refuse a write even in the cycle it pops.
REQ-013 SHALL frame each byte 8N1: start bit 0, data bits LSB first, one stop bit 1; each bit held exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-014 SHALL implement states IDLE, START, DATA, STOP; IDLE->START on FIFO non-empty (pop same edge); START->DATA, DATA->DATA for bits 0..6, DATA->STOP after bit 7, each on baud-counter terminal count.
REQ-015 SHALL, at STOP terminal count, go to START and pop if FIFO non-empty (no idle gap between frames), else IDLE.
REQ-016 SHALL run the baud counter 0..CLKS_PER_BIT-1, cleared on every state entry, wrapping to 0 at terminal count.
REQ-017 SHALL drive tx low from the edge after the accepting edge when IDLE with empty FIFO (1-cycle write-to-start latency).
REQ-018 SHALL update fifo_level by +1 on accept, -1 on pop, unchanged on simultaneous accept and pop.
REQ-019 SHALL never lose, duplicate or reorder bytes; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-020 SHALL, while rstn low at a rising edge, set tx=1, state IDLE, baud and bit counters 0, FIFO pointers and count 0, hence wr_ready=1, busy=0, fifo_level=0.
REQ-021 SHALL abort any frame in flight on reset (tx high the following edge) and discard all buffered bytes; no partial frame resumes after release.
REQ-022 SHALL NOT clear FIFO storage array on reset (pointers only).

Structure
REQ-023 SHALL place the state enum, FRAME_BITS=10, DATA_BITS=8 and UART_IDLE_LEVEL=1 in shared package uart_pkg.
REQ-024 SHALL implement buffering as sub-module uart_tx_fifo (sync FIFO, push/pop/full/empty/level), instantiated once.
REQ-025 SHALL keep the frame FSM, baud counter and shift register in uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-026 Reset: rstn low 2 cycles mid-idle -> tx=1, wr_ready=1, busy=0, fifo_level=0.
REQ-027 Single byte 0x55 -> tx 0,1,0,1,0,1,0,1,0,1 each 4 cycles, start 1 cycle after accept, busy low after 40 cycles.
REQ-028 Six consecutive writes 0x01..0x06 from idle -> 0x01..0x05 accepted, fifo_level=4, wr_ready=0 on 6th; 0x06 accepted 1 cycle after 0x02 pops; six frames back-to-back, no idle gap, order preserved.
REQ-029 Full FIFO plus write at STOP terminal count -> write refused that cycle, fifo_level 4->3, write accepted next cycle.
REQ-030 Reset during data bit 3 of 0xA5 with 2 bytes queued -> tx=1 next edge, fifo_level=0, no frame after release.
REQ-031 Bytes 0x00 then 0xFF -> 9 low bits then stop; start then 9 high bits; exact 40-cycle frames.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: frame FSM states and frame geometry.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   localparam int   FRAME_BITS      = 10;
   localparam int   DATA_BITS       = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO buffering CPU writes ahead of the serial shifter.
// Pointers and count reset; the storage array does not.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [7:0]       push_data,
   input  logic             pop,
   output logic [7:0]       pop_data,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count_q == LVL_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign level    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign push_ok  = push & ~full;
   assign pop_ok   = pop & ~empty;

   // Next pointer and occupancy values; pointers wrap naturally at the power-of-two depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array is left untouched by reset; only pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: byte FIFO in front of a frame FSM with baud counter and shifter.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | line high, waiting for a byte in the FIFO
//   ST_START | driving the start bit (low) for one bit time
//   ST_DATA  | driving data bits LSB first, bit_q counts 0..7
//   ST_STOP  | driving the stop bit (high); chains into the next frame
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         wr_valid,
   input  logic [7:0]                   wr_data,
   output logic                         wr_ready,
   output logic                         tx,
   output logic                         busy,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

   localparam int         BAUD_W   = 16;
   localparam logic [BAUD_W-1:0] BAUD_TC  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   uart_state_e       state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;

   logic              baud_tc;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [7:0]        fifo_data;

   // Readiness comes straight from the registered count, so a full FIFO refuses even while popping.
   assign wr_ready  = ~fifo_full;
   assign fifo_push = wr_valid & ~fifo_full;
   assign busy      = (state_q != ST_IDLE) | ~fifo_empty;
   assign tx        = tx_q;
   assign baud_tc   = (baud_q == BAUD_TC);

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (fifo_push),
      .push_data (wr_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // Frame sequencing: baud counter wraps at terminal count, which is also where every state change happens.
   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      fifo_pop = 1'b0;
      baud_d   = baud_tc ? '0 : baud_q + 1'b1;
      case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            if (!fifo_empty) begin
               state_d  = ST_START;
               fifo_pop = 1'b1;
               shift_d  = fifo_data;
               bit_d    = '0;
               tx_d     = ~UART_IDLE_LEVEL;
            end
         end
         ST_START: begin
            if (baud_tc) begin
               state_d = ST_DATA;
               bit_d   = '0;
               tx_d    = shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
            end
         end
         ST_DATA: begin
            if (baud_tc) begin
               if (bit_q == LAST_BIT) begin
                  state_d = ST_STOP;
                  tx_d    = UART_IDLE_LEVEL;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  tx_d    = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end
         ST_STOP: begin
            if (baud_tc) begin
               if (!fifo_empty) begin
                  state_d  = ST_START;
                  fifo_pop = 1'b1;
                  shift_d  = fifo_data;
                  bit_d    = '0;
                  tx_d     = ~UART_IDLE_LEVEL;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            baud_d  = '0;
            tx_d    = UART_IDLE_LEVEL;
         end
      endcase
   end

   // FSM, counters, shifter and the registered serial output; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= UART_IDLE_LEVEL;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized and directed bench for uart_tx with a frame-level reference model and byte scoreboard.
module tb_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_ready;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_level;

   uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: queued bytes, byte on the wire, and cycles left in its frame.
   logic [7:0] m_q [$];
   logic [7:0] sb_q [$];
   logic [7:0] m_cur = 8'h00;
   int         m_rem = 0;
   bit         last_acc = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_tx();
      int el;
      int b;
      if (m_rem == 0) return 1'b1;
      el = FRAME - m_rem;
      b  = el / CPB;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return m_cur[b-1];
   endfunction

   // Model update on each edge, then compare DUT outputs just after the edge.
   always begin
      bit acc;
      @(posedge clk);
      if (!rstn) begin
         m_q.delete();
         sb_q.delete();
         m_rem    = 0;
         last_acc = 1'b0;
      end else begin
         acc = wr_valid && (m_q.size() < DEPTH);
         if (m_q.size() > 0 && (m_rem == 0 || m_rem == 1)) begin
            m_cur = m_q.pop_front();
            m_rem = FRAME;
         end else if (m_rem > 0) begin
            m_rem--;
         end
         if (acc) begin
            m_q.push_back(wr_data);
            sb_q.push_back(wr_data);
         end
         last_acc = acc;
      end
      #1;
      check("tx", 32'(tx), 32'(model_tx()));
      check("wr_ready", 32'(wr_ready), 32'(m_q.size() < DEPTH));
      check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
      check("busy", 32'(busy), 32'(m_rem > 0 || m_q.size() > 0));
   end

   // Monitor: decode frames from the serial line and retire them against the scoreboard.
   bit         mon_active = 1'b0;
   int         mon_cnt = 0;
   logic [7:0] mon_byte = 8'h00;

   always begin
      int idx;
      @(posedge clk);
      #1;
      if (!rstn) begin
         mon_active = 1'b0;
      end else begin
         if (!mon_active) begin
            if (tx == 1'b0) begin
               mon_active = 1'b1;
               mon_cnt    = 0;
            end
         end else begin
            mon_cnt++;
         end
         if (mon_active && (mon_cnt % CPB == CPB / 2)) begin
            idx = mon_cnt / CPB;
            if (idx == 0) begin
               check("start_bit", 32'(tx), 32'd0);
            end else if (idx <= 8) begin
               mon_byte[idx-1] = tx;
            end else begin
               check("stop_bit", 32'(tx), 32'd1);
               if (sb_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL frame_unexpected: got %0h expected none at %0t", mon_byte, $time);
               end else begin
                  check("frame_byte", 32'(mon_byte), 32'(sb_q.pop_front()));
               end
               mon_active = 1'b0;
            end
         end
      end
   end

   task automatic send(input logic [7:0] b);
      int t;
      wr_valid = 1'b1;
      wr_data  = b;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!last_acc && t < 200);
      if (!last_acc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: byte %0h not accepted, expected accept within 200 cycles", b);
      end
   endtask

   task automatic idle(input int n);
      wr_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      idle(3);

      // reset mid-idle for two cycles
      rstn = 1'b0;
      idle(2);
      rstn = 1'b1;
      idle(2);

      // single byte
      send(8'h55);
      idle(FRAME + 10);

      // six back-to-back writes, sixth held until the FIFO frees a slot
      for (int i = 1; i <= 6; i++) send(8'(i));
      idle(6 * FRAME + 10);

      // reset during data bit 3 of 0xA5 with two bytes queued
      send(8'hA5);
      send(8'h11);
      send(8'h22);
      wr_valid = 1'b0;
      repeat (15) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      idle(2 * FRAME);

      // all-zero and all-one bytes
      send(8'h00);
      send(8'hFF);
      idle(2 * FRAME + 10);

      // random traffic, valid sometimes dropped while not ready
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) < 30) begin
            wr_valid = 1'b1;
            wr_data  = 8'($urandom);
         end else begin
            wr_valid = 1'b0;
         end
         @(negedge clk);
      end
      wr_valid = 1'b0;

      t = 0;
      while ((m_rem > 0 || m_q.size() > 0) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (m_rem > 0 || m_q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: model still busy after %0d cycles, expected idle", t);
      end
      idle(5);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
